// File: rtl/ram_seq_pkg.sv
// Shared encodings for the RAM access sequencer: SLS control word layout,
// access sizes, FSM states and the default beat timeout.
package ram_seq_pkg;

  localparam int SLS_RW      = 3;
  localparam int SLS_SEXT    = 2;
  localparam int SLS_SIZE_HI = 1;
  localparam int SLS_SIZE_LO = 0;

  localparam logic [1:0] SIZE_BYTE  = 2'b00;
  localparam logic [1:0] SIZE_HALF  = 2'b01;
  localparam logic [1:0] SIZE_WORD  = 2'b10;
  localparam logic [1:0] SIZE_DWORD = 2'b11;

  localparam int DEFAULT_TIMEOUT_CYCLES = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_BEAT0 = 2'b01,
    ST_BEAT1 = 2'b10,
    ST_FIN   = 2'b11
  } state_e;

  // Natural alignment: the low log2(size) address bits must be zero.
  function automatic logic is_aligned(input logic [1:0] size, input logic [2:0] lsb);
    case (size)
      SIZE_HALF:  return (lsb[0] == 1'b0);
      SIZE_WORD:  return (lsb[1:0] == 2'b00);
      SIZE_DWORD: return (lsb == 3'b000);
      default:    return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/ram_access_sequencer_load_extender.sv
// Combinational load-data formatter: right-justified RAM read data is sign- or
// zero-extended for byte and halfword loads, passed through otherwise.
module load_extender
  import ram_seq_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [1:0]  size,
  input  logic        sext,
  output logic [31:0] ext
);

  always_comb begin
    // NOTE: every output of an always_comb gets a default first so no path can infer a latch.
    ext = raw;
    case (size)
      SIZE_BYTE: ext = {{24{sext & raw[7]}}, raw[7:0]};
      SIZE_HALF: ext = {{16{sext & raw[15]}}, raw[15:0]};
      default:   ext = raw;
    endcase
  end

endmodule

// File: rtl/ram_access_sequencer.sv
// Runs one load/store per request against data RAM (two beats for a doubleword),
// with alignment checking, per-beat MFC timeout and load-data extension.
module ram_access_sequencer
  import ram_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int CNT_W          = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  sls_ctrl,
  input  logic [31:0] addr,
  input  logic [31:0] wdata_lo,
  input  logic [31:0] wdata_hi,
  output logic        busy,
  output logic        done,
  output logic        err_align,
  output logic        err_timeout,
  output logic [31:0] rdata_lo,
  output logic [31:0] rdata_hi,
  output logic        mem_en,
  output logic        mem_rw,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mfc
);

  state_e state, next_state;

  logic [3:0]       req_ctrl;
  logic [31:0]      req_addr;
  logic [31:0]      req_whi;
  logic [CNT_W-1:0] wait_cnt;
  logic             err_align_q;
  logic             err_timeout_q;
  logic [31:0]      ext_data;

  logic [1:0] start_size;
  logic [1:0] req_size;
  logic       start_aligned;
  logic       req_dword;
  logic       timeout_hit;

  assign start_size    = sls_ctrl[SLS_SIZE_HI:SLS_SIZE_LO];
  assign start_aligned = is_aligned(start_size, addr[2:0]);
  assign req_size      = req_ctrl[SLS_SIZE_HI:SLS_SIZE_LO];
  assign req_dword     = (req_size == SIZE_DWORD);
  assign timeout_hit   = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  load_extender u_ext (
    .raw  (mem_rdata),
    .size (req_size),
    .sext (req_ctrl[SLS_SEXT]),
    .ext  (ext_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (start) next_state = start_aligned ? ST_BEAT0 : ST_FIN;
      ST_BEAT0: if (mfc) next_state = req_dword ? ST_BEAT1 : ST_FIN;
                else if (timeout_hit) next_state = ST_FIN;
      ST_BEAT1: if (mfc || timeout_hit) next_state = ST_FIN;
      default:  next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    busy        = (state != ST_IDLE);
    done        = (state == ST_FIN);
    err_align   = done & err_align_q;
    err_timeout = done & err_timeout_q;
  end

  // Request latch, beat registers, wait counter and load results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_ctrl      <= '0;
      req_addr      <= '0;
      req_whi       <= '0;
      wait_cnt      <= '0;
      err_align_q   <= 1'b0;
      err_timeout_q <= 1'b0;
      rdata_lo      <= '0;
      rdata_hi      <= '0;
      mem_en        <= 1'b0;
      mem_rw        <= 1'b0;
      mem_size      <= '0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          req_ctrl      <= sls_ctrl;
          req_addr      <= addr;
          req_whi       <= wdata_hi;
          err_align_q   <= ~start_aligned;
          err_timeout_q <= 1'b0;
          wait_cnt      <= '0;
          if (start_aligned) begin
            mem_en    <= 1'b1;
            mem_rw    <= sls_ctrl[SLS_RW];
            mem_size  <= (start_size == SIZE_DWORD) ? SIZE_WORD : start_size;
            mem_addr  <= addr;
            mem_wdata <= wdata_lo;
          end
        end
        ST_BEAT0, ST_BEAT1: begin
          if (mfc) begin
            if (req_ctrl[SLS_RW]) begin
              if (state == ST_BEAT1) begin
                rdata_hi <= mem_rdata;
              end else begin
                rdata_lo <= ext_data;
                if (!req_dword) rdata_hi <= '0;
              end
            end
            if (state == ST_BEAT0 && req_dword) begin
              mem_addr  <= req_addr + 32'd4;
              mem_wdata <= req_whi;
              wait_cnt  <= '0;
            end else begin
              mem_en <= 1'b0;
            end
          end else if (timeout_hit) begin
            mem_en        <= 1'b0;
            err_timeout_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
